// File: rtl/mips_div_pkg.sv
// Shared definitions for the MIPS DIV/DIVU sequential divider.
package mips_div_pkg;

    localparam int DIV_WIDTH = 32;

    // Wide enough for any supported WIDTH; callers truncate to their width.
    localparam logic [63:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: ripple subtract via full adders, restore on borrow.

// Single-bit full-adder cell.
module mips_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module div_restore_step #(
    parameter int W = 33
) (
    input  logic [W-1:0] p_i,     // shifted partial remainder
    input  logic [W-1:0] d_i,     // divisor magnitude, zero-extended
    output logic [W-1:0] p_o,     // next partial remainder
    output logic         qbit_o   // quotient bit (no borrow)
);
    logic [W:0]   carry;
    logic [W-1:0] diff;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_fa
        mips_full_adder u_fa (
            .a_i (p_i[i]),
            .b_i (~d_i[i]),
            .c_i (carry[i]),
            .s_o (diff[i]),
            .c_o (carry[i+1])
        );
    end

    // Carry-out of p + ~d + 1 is set exactly when p >= d.
    assign qbit_o = carry[W];
    assign p_o    = qbit_o ? diff : p_i;
endmodule

// File: rtl/mips_seq_divider.sv
// Multi-cycle restoring divider for MIPS32 DIV/DIVU; LO=quotient, HI=remainder.
module mips_seq_divider
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   p_q;
    logic [WIDTH-1:0] q_q, dmag_q;
    logic [WIDTH-1:0] a_raw_q, b_raw_q;
    logic             signed_q, neg_quo_q, neg_rem_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             dbz_q, done_q;

    logic             a_neg, b_neg, div0;
    logic [WIDTH-1:0] a_mag, b_mag, r_mag;
    logic [WIDTH:0]   p_sh, p_nxt;
    logic             qbit;

    // Operands are captured raw at accept; magnitudes are formed in LOAD.
    assign a_neg = signed_q & a_raw_q[WIDTH-1];
    assign b_neg = signed_q & b_raw_q[WIDTH-1];
    assign a_mag = a_neg ? -a_raw_q : a_raw_q;
    assign b_mag = b_neg ? -b_raw_q : b_raw_q;
    assign div0  = (b_raw_q == '0);
    assign r_mag = p_q[WIDTH-1:0];

    // Upper bits of the shifted {P,Q} pair.
    assign p_sh = {p_q[WIDTH-1:0], q_q[WIDTH-1]};

    div_restore_step #(.W(WIDTH+1)) u_step (
        .p_i    (p_sh),
        .d_i    ({1'b0, dmag_q}),
        .p_o    (p_nxt),
        .qbit_o (qbit)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = div0 ? FIX : RUN;
            RUN:     if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture, load magnitudes, iterate, sign-fix and publish results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            p_q         <= '0;
            q_q         <= '0;
            dmag_q      <= '0;
            a_raw_q     <= '0;
            b_raw_q     <= '0;
            signed_q    <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == FIX);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_raw_q  <= dividend;
                        b_raw_q  <= divisor;
                        signed_q <= is_signed;
                    end
                end
                LOAD: begin
                    q_q       <= a_mag;
                    dmag_q    <= b_mag;
                    p_q       <= '0;
                    neg_quo_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    cnt_q     <= CW'(WIDTH - 1);
                end
                RUN: begin
                    p_q   <= p_nxt;
                    q_q   <= {q_q[WIDTH-2:0], qbit};
                    cnt_q <= cnt_q - CW'(1);
                end
                FIX: begin
                    if (div0) begin
                        quotient_q  <= WIDTH'(DIV0_QUOTIENT);
                        remainder_q <= a_raw_q;
                        dbz_q       <= 1'b1;
                    end else begin
                        quotient_q  <= neg_quo_q ? -q_q : q_q;
                        remainder_q <= neg_rem_q ? -r_mag : r_mag;
                        dbz_q       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Busy drops on the same edge that raises done.
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_seq_divider.sv
// Scoreboard bench for mips_seq_divider.
module tb_mips_seq_divider;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t scb[$];
    exp_t mon_e;

    mips_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit division truncates toward zero with remainder sign of dividend.
    function automatic exp_t model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sd, qq, rr;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1;
            return e;
        end
        if (sg) begin
            sa = longint'($signed(a));
            sd = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sd = longint'({32'b0, b});
        end
        qq = sa / sd;
        rr = sa % sd;
        e.q = qq[W-1:0]; e.r = rr[W-1:0]; e.dz = 1'b0;
        return e;
    endfunction

    // Result monitor: every done pops one expectation.
    always @(negedge clk) begin
        if (done) begin
            if (scb.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                mon_e = scb.pop_front();
                check("quotient", {32'b0, quotient}, {32'b0, mon_e.q});
                check("remainder", {32'b0, remainder}, {32'b0, mon_e.r});
                check("div_by_zero", {63'b0, div_by_zero}, {63'b0, mon_e.dz});
            end
        end
    end

    // Issue one request at the next edge, wait for done, check latency.
    task automatic run_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
        int n;
        int lat;
        lat = (b == '0) ? 2 : W + 2;
        scb.push_back(model(sg, a, b));
        is_signed = sg; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = $urandom; divisor = $urandom;
        check("busy_on_accept", {63'b0, busy}, 64'd1);
        n = 0;
        while (n < 100) begin
            if (inject && (n == 5 || n == 20)) begin
                start = 1'b1; dividend = 32'd7; divisor = 32'd3; is_signed = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (done) break;
        end
        check("done_seen", {63'b0, done}, 64'd1);
        check("latency", 64'(n), 64'(lat));
        check("busy_low_at_done", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_quotient", {32'b0, quotient}, 64'd0);
        check("rst_remainder", {32'b0, remainder}, 64'd0);
        check("rst_dbz", {63'b0, div_by_zero}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 32'd100, 32'd7, 1'b0);
        check("divu_100_7_q", {32'b0, quotient}, 64'd14);
        check("divu_100_7_r", {32'b0, remainder}, 64'd2);
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);
        check("div_m100_7_q", {32'b0, quotient}, 64'hFFFF_FFF2);
        check("div_m100_7_r", {32'b0, remainder}, 64'hFFFF_FFFE);
        run_op(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0);
        check("div_100_m7_q", {32'b0, quotient}, 64'hFFFF_FFF2);
        check("div_100_m7_r", {32'b0, remainder}, 64'd2);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("ovf_q", {32'b0, quotient}, 64'h8000_0000);
        check("ovf_r", {32'b0, remainder}, 64'd0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("divu_max_1_q", {32'b0, quotient}, 64'hFFFF_FFFF);

        // Divide by zero, result held while idle, then cleared by a valid op.
        run_op(1'b0, 32'h1234, 32'd0, 1'b0);
        check("dz_q", {32'b0, quotient}, 64'hFFFF_FFFF);
        check("dz_r", {32'b0, remainder}, 64'h1234);
        repeat (3) @(posedge clk);
        #1;
        check("dz_held", {63'b0, div_by_zero}, 64'd1);
        run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
        check("dz_signed_r_raw", {32'b0, remainder}, 64'hFFFF_FFFB);
        run_op(1'b0, 32'd50, 32'd5, 1'b0);
        check("dz_cleared", {63'b0, div_by_zero}, 64'd0);

        // Ignored starts mid-operation, then back-to-back accept in the done cycle.
        run_op(1'b0, 32'd100, 32'd7, 1'b1);
        run_op(1'b0, 32'd12345, 32'd77, 1'b0);
        run_op(1'b1, 32'hFFFF_0000, 32'd3, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 3) rb = '0;
            run_op(rs, ra, rb, 1'b0);
        end

        // Reset during an operation: everything clears at once, no late done.
        scb.push_back(model(1'b0, 32'd100, 32'd7));
        is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        scb.delete();
        check("mid_rst_busy", {63'b0, busy}, 64'd0);
        check("mid_rst_done", {63'b0, done}, 64'd0);
        check("mid_rst_q", {32'b0, quotient}, 64'd0);
        check("mid_rst_r", {32'b0, remainder}, 64'd0);
        check("mid_rst_dbz", {63'b0, div_by_zero}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_busy", {63'b0, busy}, 64'd0);
        check("post_rst_q", {32'b0, quotient}, 64'd0);
        run_op(1'b0, 32'd1000, 32'd10, 1'b0);
        check("post_rst_1000_10_q", {32'b0, quotient}, 64'd100);
        check("post_rst_1000_10_r", {32'b0, remainder}, 64'd0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(scb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
